// File: rtl/reg_port_master.sv
// reg_port_master: initiator for a three-port register file (two combinational
// read ports a/b, one clocked write port c). A clear sequence zeroes every
// register after reset, then commands are taken on a valid/ready interface
// and read results are returned on a valid/ready response interface.
module reg_port_master #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic          clock,
  input  logic          reset,
  // command interface
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [AW-1:0] cmd_addr_a,
  input  logic [AW-1:0] cmd_addr_b,
  input  logic [AW-1:0] cmd_addr_w,
  input  logic [DW-1:0] cmd_wdata,
  // response interface
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data_a,
  output logic [DW-1:0] rsp_data_b,
  output logic          init_done,
  // register file side
  output logic [AW-1:0] addra,
  output logic [AW-1:0] addrb,
  output logic [AW-1:0] addrc,
  output logic          enc,
  output logic [DW-1:0] datac,
  input  logic [DW-1:0] dataa,
  input  logic [DW-1:0] datab
);

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_IDLE = 2'd1,
    S_RSP  = 2'd2
  } state_t;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_ACCUM = 2'b11;

  localparam logic [AW-1:0] INIT_LAST = AW'(NREG - 1);

  state_t          state_q;
  logic [AW-1:0]   init_cnt_q;
  logic [AW-1:0]   addra_q;
  logic [AW-1:0]   addrb_q;
  logic            rsp_valid_q;
  logic            init_done_q;
  logic [DW-1:0]   rsp_data_a_q;
  logic [DW-1:0]   rsp_data_b_q;

  logic            accept;
  logic            is_write;
  logic            is_accum;
  logic            is_read;
  logic [DW-1:0]   sum;

  assign cmd_ready  = (state_q == S_IDLE);
  assign accept     = cmd_valid & cmd_ready;
  assign is_write   = accept & (cmd_op == OP_WRITE);
  assign is_accum   = accept & (cmd_op == OP_ACCUM);
  assign is_read    = accept & (cmd_op == OP_READ);
  assign sum        = dataa + datab;

  assign rsp_valid  = rsp_valid_q;
  assign init_done  = init_done_q;
  assign rsp_data_a = rsp_data_a_q;
  assign rsp_data_b = rsp_data_b_q;

  // Register-file port drive: clear pattern in INIT, command fields otherwise.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    enc   = 1'b0;
    addrc = cmd_addr_w;
    datac = cmd_wdata;
    addra = addra_q;
    addrb = addrb_q;
    unique case (state_q)
      S_INIT: begin
        enc   = 1'b1;
        addrc = init_cnt_q;
        datac = '0;
      end
      S_IDLE: begin
        addra = cmd_addr_a;
        addrb = cmd_addr_b;
        if (is_write) begin
          enc = 1'b1;
        end else if (is_accum) begin
          // sum reflects the pre-write contents, so the response is old data
          enc   = 1'b1;
          datac = sum;
        end
      end
      default: begin
        enc = 1'b0;
      end
    endcase
  end

  // Control FSM: clear sequence, command accept, response handshake.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: the response data registers are reset too, so the response bus
    // never shows stale or unknown values after reset.
    if (reset) begin
      state_q      <= S_INIT;
      init_cnt_q   <= '0;
      addra_q      <= '0;
      addrb_q      <= '0;
      rsp_valid_q  <= 1'b0;
      init_done_q  <= 1'b0;
      rsp_data_a_q <= '0;
      rsp_data_b_q <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout so every register samples
      // the pre-edge values, independent of statement order.
      unique case (state_q)
        S_INIT: begin
          init_cnt_q <= init_cnt_q + 1'b1;
          if (init_cnt_q == INIT_LAST) begin
            state_q     <= S_IDLE;
            init_done_q <= 1'b1;
          end
        end
        S_IDLE: begin
          addra_q <= cmd_addr_a;
          addrb_q <= cmd_addr_b;
          if (is_read || is_accum) begin
            rsp_data_a_q <= dataa;
            rsp_data_b_q <= datab;
            rsp_valid_q  <= 1'b1;
            state_q      <= S_RSP;
          end
        end
        S_RSP: begin
          if (rsp_valid_q && rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_INIT;
        end
      endcase
    end
  end

endmodule
